// File: rtl/wb_stream_reader_ctrl.sv
// rtl/wb_stream_reader_ctrl.sv - Wishbone burst writer draining an FWFT stream FIFO into memory
// Optional macro WB_STREAM_READER_CTRL_ERR_ABORT_EN: wbm_err_i aborts the transfer and pulses err.
module wb_stream_reader_ctrl #(
    parameter int WB_AW         = 32,
    parameter int WB_DW         = 32,
    parameter int FIFO_AW       = 4,
    parameter int MAX_BURST_LEN = 2**FIFO_AW
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    output logic [WB_AW-1:0]     wbm_adr_o,
    output logic [WB_DW-1:0]     wbm_dat_o,
    output logic [WB_DW/8-1:0]   wbm_sel_o,
    output logic                 wbm_we_o,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic [2:0]           wbm_cti_o,
    output logic [1:0]           wbm_bte_o,
    input  logic                 wbm_ack_i,
    input  logic                 wbm_err_i,
    input  logic                 wbm_rty_i,
    input  logic [WB_DW-1:0]     fifo_d,
    output logic                 fifo_rd,
    input  logic [FIFO_AW:0]     fifo_cnt,
    input  logic [WB_AW-1:0]     start_adr,
    input  logic [WB_AW-1:0]     buf_size,
    input  logic [WB_AW-1:0]     burst_size,
    input  logic                 enable,
`ifdef WB_STREAM_READER_CTRL_ERR_ABORT_EN
    output logic                 err,
`endif
    output logic                 busy,
    output logic                 done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_BURST = 2'd2;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    localparam logic [WB_AW-1:0] BYTES   = WB_AW'(WB_DW / 8);
    localparam logic [WB_AW-1:0] MAX_LEN = WB_AW'(MAX_BURST_LEN);
    localparam logic [WB_AW-1:0] ONE     = WB_AW'(1);
    localparam logic [WB_AW-1:0] TWO     = WB_AW'(2);

    logic [1:0]       state_q, state_d;
    logic [WB_AW-1:0] adr_q, adr_d;
    logic [2:0]       cti_q, cti_d;
    logic             cyc_q, cyc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WB_AW-1:0] start_adr_q, start_adr_d;
    logic [WB_AW-1:0] buf_size_q, buf_size_d;
    logic [WB_AW-1:0] burst_q, burst_d;
    logic [WB_AW-1:0] word_cnt_q, word_cnt_d;
    logic [WB_AW-1:0] beat_cnt_q, beat_cnt_d;
    logic [WB_AW-1:0] len_q, len_d;
`ifdef WB_STREAM_READER_CTRL_ERR_ABORT_EN
    logic             err_q, err_d;
`endif

    logic [WB_AW-1:0] remain;
    logic [WB_AW-1:0] len_now;
    logic [WB_AW-1:0] burst_clamped;
    logic             fifo_ok;
    logic             beat;
    logic             last_beat;

    // A retry response holds the beat exactly like a wait state.
    assign beat      = cyc_q & (wbm_ack_i | wbm_err_i) & ~wbm_rty_i;
    assign last_beat = (beat_cnt_q == len_q - ONE);
    assign remain    = buf_size_q - word_cnt_q;
    assign len_now   = (burst_q < remain) ? burst_q : remain;
    assign fifo_ok   = (WB_AW'(fifo_cnt) >= len_now);

    assign burst_clamped = (burst_size == '0)     ? ONE     :
                           (burst_size > MAX_LEN) ? MAX_LEN : burst_size;

    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = fifo_d;
    assign wbm_sel_o = '1;
    assign wbm_we_o  = 1'b1;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_cti_o = cti_q;
    assign wbm_bte_o = 2'b00;
    assign fifo_rd   = beat;
    assign busy      = busy_q;
    assign done      = done_q;
`ifdef WB_STREAM_READER_CTRL_ERR_ABORT_EN
    assign err       = err_q;
`endif

    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        cti_d       = cti_q;
        cyc_d       = cyc_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        start_adr_d = start_adr_q;
        buf_size_d  = buf_size_q;
        burst_d     = burst_q;
        word_cnt_d  = word_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        len_d       = len_q;
`ifdef WB_STREAM_READER_CTRL_ERR_ABORT_EN
        err_d       = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    start_adr_d = start_adr;
                    buf_size_d  = buf_size;
                    burst_d     = burst_clamped;
                    word_cnt_d  = '0;
                    busy_d      = 1'b1;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                // Only an empty buffer reaches WAIT with nothing left to write.
                if (remain == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (fifo_ok) begin
                    cyc_d      = 1'b1;
                    adr_d      = start_adr_q + word_cnt_q * BYTES;
                    beat_cnt_d = '0;
                    len_d      = len_now;
                    cti_d      = (len_now == ONE) ? CTI_END : CTI_INCR;
                    state_d    = S_BURST;
                end
            end
            S_BURST: begin
`ifdef WB_STREAM_READER_CTRL_ERR_ABORT_EN
                if (cyc_q && wbm_err_i) begin
                    cyc_d   = 1'b0;
                    cti_d   = CTI_CLASSIC;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else
`endif
                if (beat) begin
                    adr_d      = adr_q + BYTES;
                    beat_cnt_d = beat_cnt_q + ONE;
                    word_cnt_d = word_cnt_q + ONE;
                    if (last_beat) begin
                        cyc_d = 1'b0;
                        cti_d = CTI_CLASSIC;
                        if (word_cnt_q + ONE == buf_size_q) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end else if (beat_cnt_q + TWO == len_q) begin
                        cti_d = CTI_END;
                    end
                end
            end
            default: begin
                cyc_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= S_IDLE;
            adr_q       <= '0;
            cti_q       <= CTI_CLASSIC;
            cyc_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            start_adr_q <= '0;
            buf_size_q  <= '0;
            burst_q     <= ONE;
            word_cnt_q  <= '0;
            beat_cnt_q  <= '0;
            len_q       <= ONE;
`ifdef WB_STREAM_READER_CTRL_ERR_ABORT_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            cti_q       <= cti_d;
            cyc_q       <= cyc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            start_adr_q <= start_adr_d;
            buf_size_q  <= buf_size_d;
            burst_q     <= burst_d;
            word_cnt_q  <= word_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            len_q       <= len_d;
`ifdef WB_STREAM_READER_CTRL_ERR_ABORT_EN
            err_q       <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_wb_stream_reader_ctrl.sv
// tb/tb_wb_stream_reader_ctrl.sv - directed bench for wb_stream_reader_ctrl with FIFO and slave models
module tb_wb_stream_reader_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] adr, dat;
    logic [3:0]  sel;
    logic        we, cyc, stb;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack = 1'b0, errin = 1'b0, rty = 1'b0;
    logic [31:0] fifo_d;
    logic        fifo_rd;
    logic [4:0]  fifo_cnt;
    logic [31:0] start_adr = '0, buf_size = '0, burst_size = '0;
    logic        enable = 1'b0;
    logic        busy, done;
`ifdef WB_STREAM_READER_CTRL_ERR_ABORT_EN
    logic        err_o;
`endif

    logic [31:0] fifo_mem [0:255];
    int          wr_ptr = 0, rd_ptr = 0, pops = 0;
    logic [7:0]  rd_idx;
    assign rd_idx   = rd_ptr[7:0];
    assign fifo_d   = fifo_mem[rd_idx];
    assign fifo_cnt = 5'(wr_ptr - rd_ptr);

    wb_stream_reader_ctrl dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbm_adr_o  (adr),
        .wbm_dat_o  (dat),
        .wbm_sel_o  (sel),
        .wbm_we_o   (we),
        .wbm_cyc_o  (cyc),
        .wbm_stb_o  (stb),
        .wbm_cti_o  (cti),
        .wbm_bte_o  (bte),
        .wbm_ack_i  (ack),
        .wbm_err_i  (errin),
        .wbm_rty_i  (rty),
        .fifo_d     (fifo_d),
        .fifo_rd    (fifo_rd),
        .fifo_cnt   (fifo_cnt),
        .start_adr  (start_adr),
        .buf_size   (buf_size),
        .burst_size (burst_size),
        .enable     (enable),
`ifdef WB_STREAM_READER_CTRL_ERR_ABORT_EN
        .err        (err_o),
`endif
        .busy       (busy),
        .done       (done)
    );

    int n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        if (fifo_rd) begin
            rd_ptr <= rd_ptr + 1;
            pops   <= pops + 1;
        end
    end

    // Slave model and bus monitor: responses are chosen on the falling edge.
    logic [31:0] b_adr[$], b_dat[$], exp_q[$];
    logic [2:0]  b_cti[$];
    int          wait_mode = 0, err_at = -1, beat_idx = 0;
    int          cyc_rises = 0, cyc_hi = 0, done_cnt = 0, err_cnt = 0;
    logic        stall_prev = 1'b0, cyc_prev = 1'b0;
    logic [31:0] adr_prev = '0, dat_prev = '0;
    logic [2:0]  cti_prev = '0;

    always @(negedge clk) begin
        if (rst) begin
            ack = 1'b0; errin = 1'b0; rty = 1'b0;
            stall_prev = 1'b0; cyc_prev = 1'b0;
        end else begin
            if (stall_prev && cyc) begin
                check("stall_adr", adr, adr_prev);
                check("stall_dat", dat, dat_prev);
                check("stall_cti", 32'(cti), 32'(cti_prev));
            end
            if (cyc && !cyc_prev) cyc_rises++;
            if (cyc) cyc_hi++;
            if (done) begin
                done_cnt++;
                check("done_cyc", 32'(cyc), 32'd0);
                check("done_busy", 32'(busy), 32'd0);
            end
`ifdef WB_STREAM_READER_CTRL_ERR_ABORT_EN
            if (err_o) err_cnt++;
`endif
            ack = 1'b0; errin = 1'b0; rty = 1'b0;
            if (cyc) begin
                if (wait_mode != 0 && $urandom_range(0, 2) != 0) begin
                    rty = 1'($urandom_range(0, 1));
                end else begin
                    if (beat_idx == err_at) errin = 1'b1;
                    else ack = 1'b1;
                    b_adr.push_back(adr);
                    b_dat.push_back(dat);
                    b_cti.push_back(cti);
                    beat_idx++;
                end
            end
            stall_prev = cyc && !(ack || errin);
            adr_prev = adr; dat_prev = dat; cti_prev = cti;
            cyc_prev = cyc;
        end
    end

    logic [31:0] seq = 32'hA500_0000;
    int          pop_base = 0;

    task automatic push(input int n);
        for (int i = 0; i < n; i++) begin
            fifo_mem[8'(wr_ptr)] = seq;
            exp_q.push_back(seq);
            seq++;
            wr_ptr++;
        end
    endtask

    task automatic clear_stats();
        b_adr.delete(); b_dat.delete(); b_cti.delete();
        cyc_rises = 0; cyc_hi = 0; done_cnt = 0; err_cnt = 0; beat_idx = 0;
        pop_base = pops;
    endtask

    task automatic start_xfer(input logic [31:0] sa, input logic [31:0] bs, input logic [31:0] bu);
        @(negedge clk);
        start_adr = sa; buf_size = bs; burst_size = bu; enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        while (busy && n < max) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    function automatic logic [2:0] exp_cti(input int i, input int size, input int be);
        int pos = i % be;
        int len = size - (i - pos);
        if (len > be) len = be;
        return (pos == len - 1) ? 3'b111 : 3'b010;
    endfunction

    task automatic verify(input string tag, input int n, input logic [31:0] base,
                          input int size, input int be);
        logic [31:0] e;
        check({tag, "_beats"}, 32'(b_adr.size()), 32'(n));
        for (int i = 0; i < n && i < b_adr.size(); i++) begin
            check({tag, "_adr"}, b_adr[i], base + 32'(4 * i));
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            check({tag, "_dat"}, b_dat[i], e);
            check({tag, "_cti"}, 32'(b_cti[i]), 32'(exp_cti(i, size, be)));
        end
        check({tag, "_pops"}, 32'(pops - pop_base), 32'(n));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) fifo_mem[i] = '0;
        #1 rst = 1'b1;
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cyc", 32'(cyc), 32'd0);
        check("rst_stb", 32'(stb), 32'd0);
        check("rst_rd", 32'(fifo_rd), 32'd0);
        check("rst_adr", adr, 32'd0);
        check("rst_cti", 32'(cti), 32'd0);
        check("rst_we", 32'(we), 32'd1);
        check("rst_sel", 32'(sel), 32'hF);
        check("rst_bte", 32'(bte), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Two 4-beat bursts, zero-wait slave; a second enable mid-transfer is ignored
        push(8); clear_stats();
        start_xfer(32'h1000, 32'd8, 32'd4);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_nocyc", 32'(cyc), 32'd0);
        @(negedge clk);
        check("t1_cyc", 32'(cyc), 32'd1);
        check("t1_adr0", adr, 32'h1000);
        start_adr = 32'h9000; buf_size = 32'd3; enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        wait_idle("t1", 200);
        verify("t1", 8, 32'h1000, 8, 4);
        check("t1_done", 32'(done_cnt), 32'd1);
        check("t1_bursts", 32'(cyc_rises), 32'd2);
        check("t1_cychi", 32'(cyc_hi), 32'd8);

        // 5 words with burst 4: trailing single beat
        push(5); clear_stats();
        start_xfer(32'h2000, 32'd5, 32'd4);
        wait_idle("t2", 200);
        verify("t2", 5, 32'h2000, 5, 4);
        check("t2_bursts", 32'(cyc_rises), 32'd2);
        check("t2_done", 32'(done_cnt), 32'd1);

        // Oversized burst clamps to 16; 15 words are not enough to start
        push(15); clear_stats();
        start_xfer(32'h3000, 32'd16, 32'd64);
        repeat (30) @(negedge clk);
        check("t3_nocyc", 32'(cyc_rises), 32'd0);
        check("t3_busy", 32'(busy), 32'd1);
        push(1);
        wait_idle("t3", 200);
        verify("t3", 16, 32'h3000, 16, 16);
        check("t3_bursts", 32'(cyc_rises), 32'd1);
        check("t3_cychi", 32'(cyc_hi), 32'd16);

        // Random wait states and retries
        wait_mode = 1;
        push(12); clear_stats();
        start_xfer(32'h4000, 32'd12, 32'd5);
        wait_idle("t4", 2000);
        verify("t4", 12, 32'h4000, 12, 5);
        check("t4_bursts", 32'(cyc_rises), 32'd3);
        wait_mode = 0;

        // burst_size 0 clamps to 1; address wraps past the top of memory
        push(2); clear_stats();
        start_xfer(32'hFFFF_FFFC, 32'd2, 32'd0);
        wait_idle("t5", 200);
        verify("t5", 2, 32'hFFFF_FFFC, 2, 1);
        check("t5_bursts", 32'(cyc_rises), 32'd2);

        // Empty buffer
        clear_stats();
        start_xfer(32'h5000, 32'd0, 32'd4);
        check("t6_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("t6_done", 32'(done), 32'd1);
        check("t6_idle", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("t6_done_once", 32'(done), 32'd0);
        check("t6_nocyc", 32'(cyc_rises), 32'd0);

`ifdef WB_STREAM_READER_CTRL_ERR_ABORT_EN
        // Error on the 3rd beat of 4 aborts the transfer
        push(4); clear_stats();
        err_at = 2;
        start_xfer(32'h6000, 32'd8, 32'd4);
        wait_idle("t7", 200);
        verify("t7", 3, 32'h6000, 4, 4);
        check("t7_err", 32'(err_cnt), 32'd1);
        check("t7_nodone", 32'(done_cnt), 32'd0);
        check("t7_cyc", 32'(cyc), 32'd0);
        err_at = -1;
        wr_ptr = rd_ptr; exp_q.delete();
`endif

        // Reset mid-burst must clear the bus request without a clock edge
        push(8); clear_stats();
        start_xfer(32'h7000, 32'd8, 32'd8);
        @(negedge clk);
        check("t8_cyc", 32'(cyc), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t8_rst_cyc", 32'(cyc), 32'd0);
        check("t8_rst_stb", 32'(stb), 32'd0);
        check("t8_rst_rd", 32'(fifo_rd), 32'd0);
        check("t8_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wr_ptr = rd_ptr; exp_q.delete();
        repeat (2) @(negedge clk);
        check("t8_idle_cyc", 32'(cyc), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
